pulse_stretcher: RTL

//  Receive-side companion of the edge pulse generator. Accepts single-cycle pulses and rebuilds

---
 rtl/pulse_stretcher_pkg.sv | 24 ++
 rtl/pulse_stretcher_sat_counter.sv | 32 +++
 rtl/pulse_stretcher.sv | 116 +++++++++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher and related pulse blocks:
//   - state_t       : two-state FSM encoding (S_IDLE=1'b0, S_HOLD=1'b1)
//   - CNT_REG_W     : width of the window down-counter
//   - MAX_STRETCH   : largest window length the down-counter can hold
//   - stretchLenLegal(len) : 1 when a window length fits the down-counter
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int CNT_REG_W   = 8;
  localparam int MAX_STRETCH = (1 << CNT_REG_W) - 1;

  // Window length must be at least one cycle and fit the 8-bit down-counter.
  function automatic bit stretchLenLegal(input int len);
    return (len >= 1) && (len <= MAX_STRETCH);
  endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: counts enabled cycles and holds at all-ones instead of
// wrapping. Reusable by any pulse block that needs an event tally.
// Ports:
//   i_clk  in  1  rising-edge clock
//   i_rst  in  1  asynchronous, active-high reset (clears the count)
//   i_inc  in  1  count enable for this cycle
//   o_q    out W  current count, saturates at 2^W-1
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Receive-side companion of the edge pulse generator. Turns single-cycle pulses
// into a toggled level, a stretched window, an overrun flag and a saturating
// pulse count. All outputs come straight from flops.
// Parameters:
//   STRETCH_LEN  window length in cycles per accepted pulse (1..255)
//   CNT_W        width of o_pulse_count
//   RETRIGGER    1: pulse inside the window restarts it; 0: it is flagged overrun
// Ports:
//   i_clk          in  1      rising-edge clock
//   i_rst          in  1      asynchronous, active-high reset
//   i_pulse        in  1      input pulse, sampled every rising edge
//   o_level        out 1      toggles on every sampled pulse
//   o_stretched    out 1      high while the window is open
//   o_busy         out 1      same as o_stretched (FSM in HOLD)
//   o_overrun      out 1      one-cycle flag: pulse dropped inside the window
//   o_pulse_count  out CNT_W  sampled pulses, saturating
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int STRETCH_LEN = 4,
  parameter int CNT_W       = 8,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pulse,
  output logic             o_level,
  output logic             o_stretched,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_pulse_count
);

  // Reject window lengths the 8-bit down-counter cannot represent.
  if (!stretchLenLegal(STRETCH_LEN)) begin : g_badStretchLen
    $error("pulse_stretcher: STRETCH_LEN=%0d outside 1..%0d", STRETCH_LEN, MAX_STRETCH);
  end

  localparam logic [CNT_REG_W-1:0] RELOAD = CNT_REG_W'(STRETCH_LEN - 1);

  state_t               r_state;
  logic [CNT_REG_W-1:0] r_cnt;
  logic                 r_overrun;
  logic                 r_level;
  logic [CNT_W-1:0]     w_count;

  // r_cnt holds the number of window cycles still to come after this one, so
  // cnt==0 in HOLD marks the last window cycle. A pulse there is a fresh
  // back-to-back accept rather than an overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_pulse) begin
            r_state <= S_HOLD;
            r_cnt   <= RELOAD;
          end
        end
        S_HOLD: begin
          if (r_cnt != '0) begin
            if (i_pulse && RETRIGGER) begin
              r_cnt <= RELOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
              if (i_pulse) begin
                r_overrun <= 1'b1;
              end
            end
          end else if (i_pulse) begin
            r_cnt <= RELOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Level flips on every sampled pulse, whether or not the window accepted it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= 1'b0;
    end else if (i_pulse) begin
      r_level <= ~r_level;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_pulseCount (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_pulse),
    .o_q   (w_count)
  );

  // Window outputs decode the state flop directly, so they stay registered.
  assign o_stretched   = (r_state == S_HOLD);
  assign o_busy        = (r_state == S_HOLD);
  assign o_overrun     = r_overrun;
  assign o_level       = r_level;
  assign o_pulse_count = w_count;

endmodule
